phy_dly_seq: RTL and testbench
==============================

Name: phy_dly_seq

Overview:
- Parametrised delay-programming sequencer for the DDR3 phy. Generalises the fixed two-byte-lane, one-cmd/addr delay decode to NUM_LANES data lanes plus one cmd/addr group.
- Holds a shadow copy of every IODELAY value with a per-entry dirty bit.
- On start, streams only changed values (or all values, if forced) to the lanes as ld_delay strobes, then issues one set pulse.
- Sits between the host register interface and the byte_lane/cmd_addr instances inside the phy top.

Parameters:
- NUM_LANES, 2, number of data byte lanes; groups 0..NUM_LANES-1 are data lanes, group NUM_LANES is cmd/addr.
- DLY_WIDTH, 8, delay value width (3 LSB are the fine delay).
- SET_DELAY, 2, idle cycles between the last ld slot and the set pulse (range 0..15).
- GRP_W, clog2(NUM_LANES+1), group-select width; cfg address width is GRP_W+5.

Ports:
- clk, in, 1, clk_div-rate clock; all logic sits on this single clock.
- rst, in, 1, reset.
- cfg_we, in, 1, write one shadow entry.
- cfg_addr, in, GRP_W+5, {group, index[4:0]}.
- cfg_wdata, in, DLY_WIDTH, value to write.
- rd_addr, in, GRP_W+5, readback address.
- rd_data, out, DLY_WIDTH, shadow value at rd_addr, registered, one-cycle latency.
- start, in, 1, begin a programming pass (single-cycle pulse).
- force_all, in, 1, sampled with start: load every entry regardless of its dirty bit.
- busy, out, 1, pass in progress.
- done, out, 1, one-cycle pulse at the end of a pass.
- pending, out, 1, OR of all dirty bits.
- dly_addr, out, 5, index within the group.
- dly_data, out, DLY_WIDTH, delay value.
- ld_delay, out, NUM_LANES+1, one-hot per-group load strobe.
- set, out, 1, apply all loaded delays.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- On reset:
  - all outputs are 0, state is IDLE;
  - shadow entries are 0 and all dirty bits are cleared;
  - a reset during a pass aborts it with no set and no done.
- Writes:
  - cfg_we with group > NUM_LANES is ignored.
  - Otherwise the entry is written and its dirty bit set on the next edge.
  - Writes are accepted in every state.
- States: IDLE -> SCAN -> WAIT -> SET -> IDLE.
- IDLE:
  - start=1 goes to SCAN; busy rises on the next cycle (cycle 1); force_all is latched; scan pointer p=0.
  - start while busy is ignored.
- SCAN:
  - Lasts D = (NUM_LANES+1)*32 cycles (cycles 1..D); p visits every address in ascending order, one per cycle, and wraps only at pass end.
  - If the entry at p is dirty (or force_all is latched), the next cycle emits ld_delay one-hot bit = group(p), with dly_addr and dly_data. These ld slots fall in cycles 2..D+1.
  - The visited entry's dirty bit is cleared at that visit.
- Write collision: a cfg_we to the same address in the same cycle as its visit wins. The dirty bit stays set and new data is kept for the next pass; the old value is emitted.
- Write behind the pointer: a write to an address already passed stays dirty for the next pass.
- Outside ld slots: dly_addr/dly_data hold their last value and ld_delay=0.
- WAIT: SET_DELAY cycles.
- SET:
  - set=1 for exactly one cycle, at cycle D+2+SET_DELAY.
  - Next cycle: done=1 for one cycle and busy=0.
  - set is issued even if no entry was loaded, so the lanes re-apply their held values.
- Latency with defaults (D=96): set at cycle 100, done at cycle 101, pass length fixed regardless of dirty count.
- pending: combinational OR of all dirty bits, registered.

Decomposition:
- Package phy_dly_pkg: DLY_PER_GROUP=32, IDX_W=5, state enum {IDLE, SCAN, WAIT, SET}, function group_of(addr).
- Sub-module phy_dly_shadow: flop array plus dirty bits, write port, scan-read port with visit-clear and collision rule, registered readback.
- The FSM, counters and output registers stay in phy_dly_seq.

Test Plan:
- Reset, then start with force_all=1 -> 96 ld strobes in cycles 2..97:
  - cycles 2..33: ld_delay=3'b001, dly_addr 0..31, dly_data 0;
  - then 3'b010, then 3'b100;
  - set at cycle 100, done at cycle 101.
- Write lane1 idx 7=8'h5A and cmda idx 31=8'hC3, then start -> exactly two ld strobes:
  - ld_delay=3'b010, addr 7, data 5A at cycle 2+39;
  - ld_delay=3'b100, addr 31, data C3 at cycle 97;
  - pending drops to 0 after the pass.
- Write to cfg_addr equal to the scan pointer in its visit cycle -> old value emitted; pending=1 after done; a second pass emits the new value.
- Write to group 3 (invalid with NUM_LANES=2) -> no dirty bit set, pending stays 0; readback of the address returns 0.
- Assert rst at cycle 50 of a pass -> outputs 0 immediately, no set, no done; pending=0 afterwards; start re-runs cleanly.
- start pulses at cycles 10 and 60 of a pass -> ignored; only one set and one done; NUM_LANES=4 build gives D=160 and set at cycle 164.

Source files
------------

// File: rtl/phy_dly_pkg.sv
// Shared constants and helpers for the DDR3 phy delay-programming sequencer.
// Contents:
//   DLY_PER_GROUP / IDX_W : 32 delay taps per group, 5-bit index within a group
//   state_t / ST_*        : sequencer FSM encoding
//   group_of()            : group-select field of a {group, index} address
package phy_dly_pkg;

    localparam int DLY_PER_GROUP = 32;
    localparam int IDX_W         = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_SET  = 2'd3;

    // Upper bits of a zero-extended {group, index} address.
    function automatic logic [10:0] group_of(input logic [15:0] addr);
        return addr[15:IDX_W];
    endfunction

endpackage

// File: rtl/phy_dly_seq_if.sv
// Host/lane-side bundle of the delay sequencer.
// Ports (slave = sequencer view):
//   in : cfg_we, cfg_addr, cfg_wdata, rd_addr, start, force_all
//   out: rd_data, busy, done, pending, dly_addr, dly_data, ld_delay, set
interface phy_dly_seq_if #(
    parameter int NUM_LANES = 2,
    parameter int DLY_WIDTH = 8,
    parameter int GRP_W     = $clog2(NUM_LANES + 1)
);
    logic                   cfg_we;
    logic [GRP_W+4:0]       cfg_addr;
    logic [DLY_WIDTH-1:0]   cfg_wdata;
    logic [GRP_W+4:0]       rd_addr;
    logic [DLY_WIDTH-1:0]   rd_data;
    logic                   start;
    logic                   force_all;
    logic                   busy;
    logic                   done;
    logic                   pending;
    logic [4:0]             dly_addr;
    logic [DLY_WIDTH-1:0]   dly_data;
    logic [NUM_LANES:0]     ld_delay;
    logic                   set;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, rd_addr, start, force_all,
        input  rd_data, busy, done, pending, dly_addr, dly_data, ld_delay, set
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, rd_addr, start, force_all,
        output rd_data, busy, done, pending, dly_addr, dly_data, ld_delay, set
    );
endinterface

// File: rtl/phy_dly_shadow.sv
// Shadow store of every IODELAY value with a dirty bit per entry.
// Ports:
//   clk, rst              : clock, async active-high reset (clears values and dirty bits)
//   wr_en/wr_addr/wr_data : host write; addresses in an unused group are dropped
//   scan_en/scan_addr     : sequencer visit; clears the visited dirty bit
//   scan_data/scan_dirty  : combinational view of the visited entry (pre-write value)
//   rd_addr/rd_data       : registered readback, one-cycle latency, 0 for unused groups
//   pending               : registered OR of all dirty bits
module phy_dly_shadow
    import phy_dly_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DLY_WIDTH = 8,
    parameter int GRP_W     = $clog2(NUM_LANES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [GRP_W+4:0]       wr_addr,
    input  logic [DLY_WIDTH-1:0]   wr_data,
    input  logic                   scan_en,
    input  logic [GRP_W+4:0]       scan_addr,
    output logic [DLY_WIDTH-1:0]   scan_data,
    output logic                   scan_dirty,
    input  logic [GRP_W+4:0]       rd_addr,
    output logic [DLY_WIDTH-1:0]   rd_data,
    output logic                   pending
);

    localparam int DEPTH = (NUM_LANES + 1) * DLY_PER_GROUP;

    logic [DLY_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]     dirty_r;
    logic [DLY_WIDTH-1:0] rd_data_r;
    logic                 pending_r;
    logic                 wr_ok_s;
    logic                 rd_ok_s;

    assign wr_ok_s = wr_en && (group_of(16'(wr_addr)) <= 11'(NUM_LANES));
    assign rd_ok_s = group_of(16'(rd_addr)) <= 11'(NUM_LANES);

    assign scan_data  = mem_r[scan_addr];
    assign scan_dirty = dirty_r[scan_addr];

    // Value/dirty storage; a write in the visit cycle lands after the clear so it stays dirty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            dirty_r <= '0;
        end else begin
            if (scan_en) begin
                dirty_r[scan_addr] <= 1'b0;
            end
            if (wr_ok_s) begin
                mem_r[wr_addr]   <= wr_data;
                dirty_r[wr_addr] <= 1'b1;
            end
        end
    end

    // Registered readback and pending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= '0;
            pending_r <= 1'b0;
        end else begin
            rd_data_r <= rd_ok_s ? mem_r[rd_addr] : '0;
            pending_r <= |dirty_r;
        end
    end

    assign rd_data = rd_data_r;
    assign pending = pending_r;

endmodule

// File: rtl/phy_dly_seq.sv
// Delay-programming sequencer: shadows all lane and cmd/addr IODELAY values
// and, on start, streams dirty (or all) entries as ld_delay strobes followed
// by a single set pulse. Pass length is fixed regardless of how many load.
// Ports:
//   clk, rst : single clk_div-rate clock, async active-high reset
//   bus      : phy_dly_seq_if.slave (config/readback, start/force_all,
//              busy/done/pending status, dly_addr/dly_data/ld_delay/set to lanes)
module phy_dly_seq
    import phy_dly_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DLY_WIDTH = 8,
    parameter int SET_DELAY = 2,
    parameter int GRP_W     = $clog2(NUM_LANES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    phy_dly_seq_if.slave bus
);

    localparam int NG    = NUM_LANES + 1;
    localparam int AW    = GRP_W + IDX_W;
    localparam int DEPTH = NG * DLY_PER_GROUP;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t               state_r;
    logic [AW-1:0]        ptr_r;
    logic [4:0]           wait_cnt_r;
    logic                 force_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 set_r;
    logic [NG-1:0]        ld_r;
    logic [4:0]           dly_addr_r;
    logic [DLY_WIDTH-1:0] dly_data_r;

    logic                 scan_en_s;
    logic [DLY_WIDTH-1:0] scan_data_s;
    logic                 scan_dirty_s;
    logic [DLY_WIDTH-1:0] rd_data_s;
    logic                 pending_s;

    assign scan_en_s = (state_r == ST_SCAN);

    phy_dly_shadow #(
        .NUM_LANES (NUM_LANES),
        .DLY_WIDTH (DLY_WIDTH),
        .GRP_W     (GRP_W)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (bus.cfg_we),
        .wr_addr    (bus.cfg_addr),
        .wr_data    (bus.cfg_wdata),
        .scan_en    (scan_en_s),
        .scan_addr  (ptr_r),
        .scan_data  (scan_data_s),
        .scan_dirty (scan_dirty_s),
        .rd_addr    (bus.rd_addr),
        .rd_data    (rd_data_s),
        .pending    (pending_s)
    );

    // Pass FSM: scan every address once, wait SET_DELAY+1 cycles after the last visit, pulse set, then done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            wait_cnt_r <= 5'd0;
            force_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            set_r      <= 1'b0;
            ld_r       <= '0;
            dly_addr_r <= 5'd0;
            dly_data_r <= '0;
        end else begin
            ld_r   <= '0;
            set_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r <= ST_SCAN;
                        busy_r  <= 1'b1;
                        force_r <= bus.force_all;
                        ptr_r   <= '0;
                    end
                end
                ST_SCAN: begin
                    // Emit the pre-write value; the shadow keeps a colliding write dirty.
                    if (scan_dirty_s || force_r) begin
                        ld_r       <= NG'(1'b1) << ptr_r[AW-1:IDX_W];
                        dly_addr_r <= ptr_r[IDX_W-1:0];
                        dly_data_r <= scan_data_s;
                    end
                    if (ptr_r == LAST_PTR) begin
                        ptr_r      <= '0;
                        wait_cnt_r <= 5'd0;
                        state_r    <= ST_WAIT;
                    end else begin
                        ptr_r <= ptr_r + AW'(1);
                    end
                end
                ST_WAIT: begin
                    // First WAIT cycle carries the last ld slot, so SET_DELAY idle cycles follow it.
                    if (wait_cnt_r == 5'(SET_DELAY)) begin
                        set_r   <= 1'b1;
                        state_r <= ST_SET;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 5'd1;
                    end
                end
                ST_SET: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.set      = set_r;
    assign bus.ld_delay = ld_r;
    assign bus.dly_addr = dly_addr_r;
    assign bus.dly_data = dly_data_r;
    assign bus.rd_data  = rd_data_s;
    assign bus.pending  = pending_s;

endmodule

// File: tb/tb_phy_dly_seq.sv
// Self-checking bench for phy_dly_seq with a behavioural shadow/dirty model.
module tb_phy_dly_seq;

    localparam int NL       = 2;
    localparam int DW       = 8;
    localparam int SD       = 2;
    localparam int GW       = $clog2(NL + 1);
    localparam int AW       = GW + 5;
    localparam int NE       = (NL + 1) * 32;
    localparam int D        = NE;
    localparam int SET_CYC  = D + 2 + SD;
    localparam int DONE_CYC = D + 3 + SD;
    localparam int CYC_END  = D + SD + 6;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [DW-1:0] shadow_m [NE];
    bit            dirty_m  [NE];
    logic [4:0]    hold_a;
    logic [DW-1:0] hold_d;

    phy_dly_seq_if #(.NUM_LANES(NL), .DLY_WIDTH(DW), .GRP_W(GW)) bus ();

    phy_dly_seq #(.NUM_LANES(NL), .DLY_WIDTH(DW), .SET_DELAY(SD), .GRP_W(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) begin
            shadow_m[i] = '0;
            dirty_m[i]  = 1'b0;
        end
        hold_a = 5'd0;
        hold_d = '0;
    endfunction

    function automatic void model_write(input int a, input logic [DW-1:0] d);
        if (a < NE) begin
            shadow_m[a] = d;
            dirty_m[a]  = 1'b1;
        end
    endfunction

    function automatic logic model_pending();
        logic p = 1'b0;
        for (int i = 0; i < NE; i++) p = p | dirty_m[i];
        return p;
    endfunction

    task automatic cfg_write(input int a, input logic [DW-1:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = AW'(a);
        bus.cfg_wdata = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic test_readback(input int a);
        logic [DW-1:0] exp_d;
        exp_d = (a < NE) ? shadow_m[a] : '0;
        bus.rd_addr = AW'(a);
        @(negedge clk);
        checks++;
        if (bus.rd_data !== exp_d) begin
            failures++;
            $display("FAIL readback addr=%0d got=%h exp=%h", a, bus.rd_data, exp_d);
        end
    endtask

    // One full pass; expectations come from walking the model address by address.
    task automatic run_pass(input bit f, input bit wr_en, input int wr_cyc, input int wr_a,
                            input logic [DW-1:0] wr_d, input bit ign_start);
        logic [NL:0]   e_ld [0:CYC_END];
        logic [4:0]    e_a  [0:CYC_END];
        logic [DW-1:0] e_d  [0:CYC_END];
        int            exp_n;
        int            nld;
        for (int c = 0; c <= CYC_END; c++) begin
            e_ld[c] = '0; e_a[c] = 5'd0; e_d[c] = '0;
        end
        exp_n = 0;
        nld   = 0;
        for (int c = 1; c <= D; c++) begin
            int a = c - 1;
            if (dirty_m[a] || f) begin
                e_ld[c + 1][a / 32] = 1'b1;
                e_a[c + 1] = 5'(a % 32);
                e_d[c + 1] = shadow_m[a];
                exp_n++;
            end
            dirty_m[a] = 1'b0;
            if (wr_en && wr_cyc == c) model_write(wr_a, wr_d);
        end
        if (wr_en && wr_cyc > D) model_write(wr_a, wr_d);

        bus.start = 1'b1;
        bus.force_all = f;
        @(negedge clk);
        bus.start = 1'b0;
        bus.force_all = 1'b0;
        for (int c = 1; c <= CYC_END; c++) begin
            checks++;
            if (bus.busy !== 1'(c <= SET_CYC)) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", c, bus.busy, c <= SET_CYC);
            end
            checks++;
            if (bus.ld_delay !== e_ld[c]) begin
                failures++;
                $display("FAIL ld_delay cyc=%0d got=%b exp=%b", c, bus.ld_delay, e_ld[c]);
            end
            if (e_ld[c] != '0) begin
                hold_a = e_a[c];
                hold_d = e_d[c];
            end
            if (bus.ld_delay != '0) nld++;
            checks++;
            if (bus.dly_addr !== hold_a || bus.dly_data !== hold_d) begin
                failures++;
                $display("FAIL dly cyc=%0d got=%0d/%h exp=%0d/%h", c, bus.dly_addr, bus.dly_data, hold_a, hold_d);
            end
            checks++;
            if (bus.set !== 1'(c == SET_CYC) || bus.done !== 1'(c == DONE_CYC)) begin
                failures++;
                $display("FAIL set_done cyc=%0d got=%b%b exp=%b%b", c, bus.set, bus.done,
                         c == SET_CYC, c == DONE_CYC);
            end
            bus.cfg_we = 1'b0;
            bus.start  = 1'b0;
            if (wr_en && c == wr_cyc) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = AW'(wr_a);
                bus.cfg_wdata = wr_d;
            end
            if (ign_start && (c == 10 || c == 60)) bus.start = 1'b1;
            @(negedge clk);
        end
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        checks++;
        if (nld != exp_n) begin
            failures++;
            $display("FAIL ld_count got=%0d exp=%0d", nld, exp_n);
        end
        checks++;
        if (bus.pending !== model_pending()) begin
            failures++;
            $display("FAIL pending_after got=%b exp=%b", bus.pending, model_pending());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.set, bus.ld_delay, bus.dly_addr, bus.dly_data, bus.pending, bus.rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {bus.busy, bus.done, bus.set, bus.ld_delay,
                     bus.dly_addr, bus.dly_data, bus.pending, bus.rd_data});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        test_readback(0);
    endtask

    task automatic test_force_all();
        run_pass(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
    endtask

    task automatic test_sparse();
        cfg_write(32 + 7, 8'h5A);
        cfg_write(64 + 31, 8'hC3);
        @(negedge clk);
        checks++;
        if (bus.pending !== 1'b1) begin
            failures++;
            $display("FAIL pending_set got=%b exp=1", bus.pending);
        end
        run_pass(1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
        test_readback(39);
    endtask

    task automatic test_collision();
        cfg_write(20, 8'h11);
        run_pass(1'b0, 1'b1, 21, 20, 8'h77, 1'b0);
        checks++;
        if (bus.pending !== 1'b1) begin
            failures++;
            $display("FAIL collision_pending got=%b exp=1", bus.pending);
        end
        run_pass(1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
        test_readback(20);
    endtask

    task automatic test_invalid_group();
        cfg_write(3 * 32 + 9, 8'hE7);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.pending !== 1'b0) begin
            failures++;
            $display("FAIL invalid_pending got=%b exp=0", bus.pending);
        end
        test_readback(3 * 32 + 9);
    endtask

    task automatic test_start_ignored();
        cfg_write(5, 8'h42);
        run_pass(1'b0, 1'b0, 0, 0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_abort();
        bit seen;
        cfg_write(10, 8'h3C);
        cfg_write(50, 8'h81);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (49) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before got=%b exp=1", bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.set, bus.ld_delay, bus.dly_addr, bus.dly_data, bus.pending} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got=%b exp=0", {bus.busy, bus.done, bus.set, bus.ld_delay,
                     bus.dly_addr, bus.dly_data, bus.pending});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int c = 0; c < D + 20; c++) begin
            if (bus.set || bus.done || bus.busy || bus.pending) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet got=%b exp=0", seen);
        end
        test_readback(50);
        run_pass(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int n;
            int wc;
            int wa;
            bit f;
            bit we;
            n = $urandom_range(0, 8);
            for (int k = 0; k < n; k++) begin
                cfg_write($urandom_range(0, (1 << AW) - 1), DW'($urandom));
            end
            f  = ($urandom_range(0, 3) == 0);
            we = 1'($urandom_range(0, 1));
            wc = $urandom_range(1, D + 2);
            wa = ($urandom_range(0, 1) == 1 && wc <= D) ? wc - 1 : $urandom_range(0, (1 << AW) - 1);
            run_pass(f, we, wc, wa, DW'($urandom), 1'b0);
            test_readback($urandom_range(0, (1 << AW) - 1));
            test_readback(wa);
        end
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.rd_addr   = '0;
        bus.start     = 1'b0;
        bus.force_all = 1'b0;
        rst           = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_force_all();
        test_sparse();
        test_collision();
        test_invalid_group();
        test_start_ignored();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
